// File: rtl/neo_pass_ctrl.sv
// NEO pass sequencer: streams x[0..M-1] from memory, writes
// psi[n] = x[n]^2 - x[n-1]*x[n+1] to M..2M-1, counts threshold crossings.
module neo_pass_ctrl #(
  parameter  int N  = 16,
  parameter  int M  = 16,
  localparam int AW = $clog2(M) + 1
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] threshold,
  input  logic signed [N-1:0] rdata,
  output logic [AW-1:0]       raddr,
  output logic [AW-1:0]       waddr,
  output logic signed [N-1:0] wdata,
  output logic                we,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       spike_count
);

  localparam int CW = $clog2(M + 5);

  localparam logic signed [2*N:0] PMAX =
    {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] PMIN =
    {{(N+2){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_TAIL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic signed [N-1:0] wdata_q, wdata_d;
  logic signed [N-1:0] thr_q, thr_d;
  logic signed [N-1:0] xp_q, xp_d;
  logic signed [N-1:0] xc_q, xc_d;
  logic                we_q, we_d;

  logic signed [2*N-1:0] sq, xx;
  logic signed [2*N:0]   diff, shr;
  logic signed [N-1:0]   psi;
  logic                  run;
  logic                  psi_en;

  // rdata is the x_next slot of the window, used before it is shifted in
  always_comb begin
    sq   = (2*N)'(xc_q) * (2*N)'(xc_q);
    xx   = (2*N)'(xp_q) * (2*N)'(rdata);
    diff = {sq[2*N-1], sq} - {xx[2*N-1], xx};
    shr  = diff >>> (N-1);
    if (shr > PMAX) begin
      psi = {1'b0, {(N-1){1'b1}}};
    end else if (shr < PMIN) begin
      psi = {1'b1, {(N-1){1'b0}}};
    end else begin
      psi = shr[N-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    xp_d    = xp_q;
    xc_d    = xc_q;

    run    = (state_q != S_IDLE);
    psi_en = run && (cyc_q >= CW'(4))
                 && (cyc_q <= CW'(M + 1));

    if (run) begin
      cyc_d = cyc_q + 1'b1;
    end

    if (run && (cyc_q >= CW'(2))
            && (cyc_q <= CW'(M + 1))) begin
      xp_d = xc_q;
      xc_d = rdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cyc_d   = CW'(1);
          raddr_d = '0;
          cnt_d   = '0;
          thr_d   = threshold;
          xp_d    = '0;
          xc_d    = '0;
        end
      end
      S_READ: begin
        raddr_d = AW'(cyc_q);
        if (cyc_q == CW'(M - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cyc_q == CW'(M + 2)) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_READ && cyc_q == CW'(1)) begin
      we_d    = 1'b1;
      waddr_d = AW'(M);
      wdata_d = '0;
    end

    if (psi_en) begin
      we_d    = 1'b1;
      waddr_d = AW'(M - 3) + AW'(cyc_q);
      wdata_d = psi;
      if (psi > thr_q) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (state_q == S_DRAIN && cyc_q == CW'(M + 2)) begin
      we_d    = 1'b1;
      waddr_d = AW'(2 * M - 1);
      wdata_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      thr_q   <= '0;
      xp_q    <= '0;
      xc_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      xp_q    <= xp_d;
      xc_q    <= xc_d;
    end
  end

  assign raddr       = raddr_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign we          = we_q;
  assign spike_count = cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_neo_pass_ctrl.sv
// Scoreboard bench for neo_pass_ctrl: arithmetic reference model,
// expected writes/done queued at issue, monitor checks at negedge.
module tb_neo_pass_ctrl;
  localparam int N  = 16;
  localparam int M  = 16;
  localparam int AW = $clog2(M) + 1;

  logic                Clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] threshold = '0;
  logic signed [N-1:0] rdata = '0;
  logic [AW-1:0]       raddr, waddr, spike_count;
  logic signed [N-1:0] wdata;
  logic                we, busy, done;

  neo_pass_ctrl #(.N(N), .M(M)) dut (
    .Clk(Clk), .reset(reset), .start(start),
    .threshold(threshold), .rdata(rdata),
    .raddr(raddr), .waddr(waddr), .wdata(wdata),
    .we(we), .busy(busy), .done(done),
    .spike_count(spike_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic signed [N-1:0] mem [0:2*M-1];
  always @(posedge Clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] = wdata;
  end

  typedef struct { int c; int addr; int data; } wr_t;
  typedef struct { int c; int cnt; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t ew;
  dn_t ed;
  int  bs = 0, be = -1;
  int  nchk = 0, nfail = 0;

  int xs [M];
  int exp_psi [M];
  int exp_cnt;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, floor division, clamp
  function automatic void model(input int thr);
    longint s = longint'(1) << (N - 1);
    longint d, q;
    exp_cnt = 0;
    for (int n = 0; n < M; n++) begin
      if (n == 0 || n == M - 1) begin
        exp_psi[n] = 0;
      end else begin
        d = longint'(xs[n]) * xs[n] - longint'(xs[n-1]) * xs[n+1];
        q = d / s;
        if (d < 0 && (d % s) != 0) q = q - 1;
        if (q > s - 1) q = s - 1;
        if (q < -s) q = -s;
        exp_psi[n] = int'(q);
        if (n <= M - 2 && exp_psi[n] > thr) exp_cnt++;
      end
    end
  endfunction

  always @(negedge Clk) begin
    if (reset) begin
      chk("busy", busy, (cyc >= bs && cyc <= be) ? 1 : 0);
      if (we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", waddr, -1);
        end else begin
          ew = wq.pop_front();
          chk("wr_cycle", cyc, ew.c);
          chk("wr_addr", waddr, ew.addr);
          chk("wr_data", wdata, ew.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done_cycle", cyc, -1);
        end else begin
          ed = dq.pop_front();
          chk("done_cycle", cyc, ed.c);
          chk("done_spike_count", spike_count, ed.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_x(input int k, input int v);
    xs[k] = v;
    mem[k] = N'(v);
  endtask

  task automatic clear_x();
    for (int k = 0; k < M; k++) set_x(k, 0);
  endtask

  task automatic poison();
    for (int k = M; k < 2 * M; k++) mem[k] = 16'sh5A5A;
  endtask

  // Called just after a posedge while the DUT is idle
  task automatic issue(input int thr, output int t);
    threshold = N'(thr);
    start = 1'b1;
    t = cyc;
    model(thr);
    wq.push_back('{t + 2, M, 0});
    for (int k = 2; k < M; k++)
      wq.push_back('{t + 3 + k, M + k - 1, exp_psi[k-1]});
    wq.push_back('{t + M + 3, 2 * M - 1, 0});
    dq.push_back('{t + M + 4, exp_cnt});
    bs = t + 1;
    be = t + M + 4;
  endtask

  task automatic wait_done();
    for (int i = 0; i < M + 12 && dq.size() != 0; i++) tick();
    chk("pending_after_timeout", wq.size() + dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  task automatic check_mem(input string nm);
    for (int n = 0; n < M; n++)
      chk({nm, "_mem"}, mem[M + n], exp_psi[n]);
    chk({nm, "_spike_count"}, spike_count, exp_cnt);
  endtask

  task automatic run(input string nm, input int thr);
    int t;
    tick();
    poison();
    issue(thr, t);
    tick();
    start = 1'b0;
    wait_done();
    tick();
    check_mem(nm);
  endtask

  task automatic chk_zero(input string nm);
    @(negedge Clk);
    chk({nm, "_raddr"}, raddr, 0);
    chk({nm, "_waddr"}, waddr, 0);
    chk({nm, "_wdata"}, wdata, 0);
    chk({nm, "_we"}, we, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_spike_count"}, spike_count, 0);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    wq.delete();
    dq.delete();
    be = -1;
    chk_zero(nm);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, thr;
    for (int k = 0; k < 2 * M; k++) mem[k] = '0;
    for (int k = 0; k < M; k++) xs[k] = 0;
    tick();
    tick();
    chk_zero("reset");
    tick();
    reset = 1'b1;

    for (int k = 0; k < M; k++) set_x(k, 16384);
    run("flat", 0);
    chk("flat_count_const", spike_count, 0);

    clear_x();
    set_x(5, 16384);
    run("pulse", 4096);
    chk("pulse_mem21", mem[21], 8192);
    chk("pulse_mem20", mem[20], 0);
    chk("pulse_mem22", mem[22], 0);
    chk("pulse_count", spike_count, 1);

    tick();
    do_reset("idle_reset");
    repeat (4) tick();

    clear_x();
    set_x(7, -32768);
    run("satpos", 0);
    chk("satpos_mem23", mem[23], 32767);

    clear_x();
    set_x(6, 32767);
    set_x(8, 32767);
    run("satneg", 0);
    chk("satneg_mem23", mem[23], -32767);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < M; k++)
        if (r % 2 == 0) set_x(k, int'($signed(16'($urandom))));
        else set_x(k, int'($urandom_range(0, 16383)) - 8192);
      thr = int'($urandom_range(0, 8000)) - 4000;
      run("rand", thr);
    end

    for (int k = 0; k < M; k++) set_x(k, int'($urandom_range(0, 20000)) - 10000);
    thr = 100;
    tick();
    poison();
    issue(thr, t);
    while (cyc < t + M + 5) tick();
    start = 1'b0;
    wait_done();
    repeat (M + 8) tick();
    check_mem("hold");

    tick();
    poison();
    issue(thr, t1);
    tick();
    start = 1'b0;
    while (cyc < t1 + M + 5) tick();
    check_mem("b2b_first");
    poison();
    issue(thr, t);
    chk("b2b_gap", t - t1, M + 5);
    tick();
    start = 1'b0;
    wait_done();
    tick();
    check_mem("b2b_second");

    for (int k = 0; k < M; k++) set_x(k, int'($signed(16'($urandom))));
    thr = -500;
    tick();
    poison();
    issue(thr, t);
    tick();
    start = 1'b0;
    while (cyc < t + 8) tick();
    do_reset("pass_reset");
    repeat (M + 8) tick();
    run("restart", thr);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
